spi_frame_tx: RTL and testbench

Serializing transmitter for the three-phase framed serial link consumed by the `fsm` receiver. It accepts a parallel word on a valid/ready handshake and emits it MSB first on `SPIin`/`spi_en`. Each bit is framed as a marker `1`, then the data bit, then a space `0`, with `spi_en` high for all three cycles. It is the on-chip source for the receiver path and replaces the behavioural stimulus generator used in benches.

---
 rtl/spi_frame_tx.sv | 126 ++++++++++++
 tb/tb_spi_frame_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_tx.sv
// ============================================================================
// Module   : spi_frame_tx
// Function : Framed serial transmitter; each bit is sent as MARK(1), DATA, SPACE(0)
//            with spi_en high for all three cycles. Optional even-parity triplet
//            is enabled by defining SPI_FRAME_TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              SPIin,
  output logic              spi_en,
  output logic              busy,
  output logic              done
);

`ifdef SPI_FRAME_TX_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int BW = $clog2(NBITS + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MARK  = 3'd1,
    S_DATA  = 3'd2,
    S_SPACE = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [NBITS-1:0] w_load_word;

`ifdef SPI_FRAME_TX_PARITY_EN
  // Parity rides in the LSB slot so it leaves the shifter after the data LSB.
  assign w_load_word = {tx_data, ^tx_data};
`else
  assign w_load_word = tx_data;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Outputs decode only registered state, so reset clears them asynchronously.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    tx_ready  = 1'b0;
    SPIin     = 1'b0;
    spi_en    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
        if (tx_valid) begin
          shreg_d   = w_load_word;
          bit_cnt_d = '0;
          state_d   = S_MARK;
        end
      end
      S_MARK: begin
        SPIin   = 1'b1;
        spi_en  = 1'b1;
        state_d = S_DATA;
      end
      S_DATA: begin
        SPIin   = shreg_q[NBITS-1];
        spi_en  = 1'b1;
        shreg_d = shreg_q << 1;
        state_d = S_SPACE;
      end
      S_SPACE: begin
        spi_en    = 1'b1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BW'(NBITS - 1)) begin
          done      = 1'b1;
          gap_cnt_d = '0;
          state_d   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end else begin
          state_d = S_MARK;
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_frame_tx.sv
// ============================================================================
// Module   : tb_spi_frame_tx
// Function : Self-checking bench for spi_frame_tx (GAP 0 and GAP 4 instances).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_frame_tx;

  localparam int W = 8;
`ifdef SPI_FRAME_TX_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  localparam int FR    = 3 * NB;
  localparam int GAP_B = 4;

  // rdy, en, sin, busy, done
  typedef logic [4:0] obs_t;
  typedef obs_t obs_q_t[$];
  localparam obs_t IDLE_OBS = 5'b10000;

  typedef struct {
    logic [W-1:0] data;
    logic [23:0]  stream;
    logic         par;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] da = '0, db = '0;
  logic         va = 1'b0, vb = 1'b0;
  logic         ra, sa, ea, ba, dna;
  logic         rb, sb, eb, bb, dnb;
  int           n_tests = 0;
  int           n_fail  = 0;
  obs_q_t       qa, qb;
  vec_t         vt[6];
  logic         en_log[1:80];
  logic         sin_log[1:80];

  spi_frame_tx #(.DATA_W(W), .GAP_CYCLES(0)) dut_a (
    .clock(clk), .reset(rst), .tx_data(da), .tx_valid(va), .tx_ready(ra),
    .SPIin(sa), .spi_en(ea), .busy(ba), .done(dna)
  );

  spi_frame_tx #(.DATA_W(W), .GAP_CYCLES(GAP_B)) dut_b (
    .clock(clk), .reset(rst), .tx_data(db), .tx_valid(vb), .tx_ready(rb),
    .SPIin(sb), .spi_en(eb), .busy(bb), .done(dnb)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Expected per-cycle observation sequence of one word, derived from the frame rules.
  function automatic obs_q_t frames(input logic [W-1:0] d, input int gap);
    obs_q_t       q;
    logic [NB-1:0] bits;
`ifdef SPI_FRAME_TX_PARITY_EN
    bits = {d, ^d};
`else
    bits = d;
`endif
    for (int i = NB - 1; i >= 0; i--) begin
      q.push_back(5'b01110);
      q.push_back({2'b01, bits[i], 2'b10});
      q.push_back({4'b0101, (i == 0)});
    end
    for (int g = 0; g < gap; g++) q.push_back(5'b00010);
    return q;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (qa.size() > 0) void'(qa.pop_front());
      else if (va) qa = frames(da, 0);
      if (qb.size() > 0) void'(qb.pop_front());
      else if (vb) qb = frames(db, GAP_B);
    end
  end

  always @(negedge clk) begin
    check("model_a", 32'({ra, ea, sa, ba, dna}), 32'((qa.size() > 0) ? qa[0] : IDLE_OBS));
    check("model_b", 32'({rb, eb, sb, bb, dnb}), 32'((qb.size() > 0) ? qb[0] : IDLE_OBS));
  end

  // Raises tx_valid at the start of a cycle and returns right after the handshake edge.
  task automatic send_a(input logic [W-1:0] d, output int waits);
    waits = 0;
    va = 1'b1;
    da = d;
    @(negedge clk);
    while (!ra && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    check("handshake_timeout", 32'(waits < 200), 32'd1);
    @(posedge clk);
    #1;
    va = 1'b0;
  endtask

  task automatic capture_word(input logic [23:0] exp_stream, input logic exp_par);
    logic [26:0] s;
    int          en_cnt;
    int          done_at;
    s       = '0;
    en_cnt  = 0;
    done_at = 0;
    for (int k = 1; k <= FR + 1; k++) begin
      @(negedge clk);
      if (k <= FR) begin
        en_cnt += int'(ea);
        s = {s[25:0], sa};
      end
      if (dna) done_at = k;
      if (k == FR + 1) check("ready_back", 32'({ra, ea}), 32'b10);
      @(posedge clk);
      #1;
    end
    check("frame_cycles", 32'(en_cnt), 32'(FR));
    check("done_cycle", 32'(done_at), 32'(FR));
`ifdef SPI_FRAME_TX_PARITY_EN
    check("stream", 32'(s[26:3]), 32'(exp_stream));
    check("parity_triplet", 32'(s[2:0]), 32'({1'b1, exp_par, 1'b0}));
`else
    check("stream", 32'(s[23:0]), 32'(exp_stream));
`endif
  endtask

  initial begin
    int waits;
    int zeros;
    logic [23:0] st;

    vt[0] = '{8'hA5, 24'b110100110100100110100110, 1'b0};
    vt[1] = '{8'h3C, 24'b100100110110110110100100, 1'b0};
    vt[2] = '{8'h81, 24'b110100100100100100100110, 1'b0};
    vt[3] = '{8'h07, 24'b100100100100100110110110, 1'b1};
    vt[4] = '{8'h00, 24'b100100100100100100100100, 1'b0};
    vt[5] = '{8'hFF, 24'b110110110110110110110110, 1'b0};

    // Reset held for 5 cycles, then released with tx_valid low.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("reset_hold_a", 32'({ra, ea, sa, ba, dna}), 32'(IDLE_OBS));
      check("reset_hold_b", 32'({rb, eb, sb, bb, dnb}), 32'(IDLE_OBS));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("reset_release_a", 32'({ra, ea, sa, ba, dna}), 32'(IDLE_OBS));
    end
    @(posedge clk);
    #1;

    foreach (vt[i]) begin
      send_a(vt[i].data, waits);
      capture_word(vt[i].stream, vt[i].par);
    end

    // Back-to-back: tx_valid held across 8'h00 then 8'hFF.
    va = 1'b1;
    da = 8'h00;
    @(negedge clk);
    check("b2b_ready", 32'(ra), 32'd1);
    @(posedge clk);
    #1;
    da = 8'hFF;
    for (int k = 1; k <= 2 * FR + 1; k++) begin
      @(negedge clk);
      en_log[k]  = ea;
      sin_log[k] = sa;
      @(posedge clk);
      #1;
      if (k == FR + 1) va = 1'b0;
    end
    zeros = 0;
    for (int k = 1; k <= 2 * FR + 1; k++) if (!en_log[k]) zeros++;
    check("b2b_idle_cycles", 32'(zeros), 32'd1);
    check("b2b_idle_pos", 32'(en_log[FR + 1]), 32'd0);
    st = '0;
    for (int k = FR + 2; k < FR + 2 + 24; k++) st = {st[22:0], sin_log[k]};
    check("b2b_second_word", 32'(st), 32'(24'b110110110110110110110110));

    // Gap: GAP_CYCLES=4 instance, two back-to-back words.
    vb = 1'b1;
    db = 8'h96;
    @(negedge clk);
    check("gap_ready", 32'(rb), 32'd1);
    @(posedge clk);
    #1;
    db = 8'h5A;
    for (int k = 1; k <= 2 * FR + 5; k++) begin
      @(negedge clk);
      en_log[k] = eb;
      @(posedge clk);
      #1;
      if (k == FR + 5) vb = 1'b0;
    end
    zeros = 0;
    for (int k = 1; k <= 2 * FR + 5; k++) if (!en_log[k]) zeros++;
    check("gap_idle_cycles", 32'(zeros), 32'd5);
    check("gap_edges", 32'({en_log[FR], en_log[FR + 1], en_log[FR + 5], en_log[FR + 6]}), 32'b1001);

    // Mid-word reset during the DATA phase of bit 3 of 8'h3C.
    send_a(8'h3C, waits);
    repeat (13) @(posedge clk);
    #3;
    check("pre_reset_data_bit3", 32'({ea, sa}), 32'b11);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", 32'({ra, ea, sa, ba, dna}), 32'(IDLE_OBS));
    repeat (2) begin
      @(negedge clk);
      check("reset_no_done", 32'(dna), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_a(8'h81, waits);
    check("first_edge_handshake", 32'(waits), 32'd0);
    capture_word(vt[2].stream, vt[2].par);

    // Randomized traffic on both instances, checked by the per-cycle model.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #1;
      va = ($urandom_range(0, 2) == 0);
      da = W'($urandom);
      vb = ($urandom_range(0, 3) == 0);
      db = W'($urandom);
    end
    va = 1'b0;
    vb = 1'b0;
    repeat (80) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
